handshake_receiver: RTL
=======================

# handshake_receiver

Receive end of the 8-bit valid/ready stream produced by the handshake sender. The block accepts beats into a small FIFO, drains them to a local consumer under randomized stall control, and checks that the drained data follows the sender's incrementing sequence. It is the sink side of the handshake testbench pair and provides accept/error statistics for self-checking simulation.

## Interface
- DW, 8: data width; must match the sender's data width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous assert, active-high. Release is synchronous to clk externally.
- random_stall  in  1  local consumer enable: 1 = pop one entry this cycle if not empty; 0 = consumer stalls.
- valid_i  in  1  beat valid from the sender.
- data_i  in  DW  beat data from the sender.
- ready_o  out  1  accept capability to the sender; registered.
- pop_valid_o  out  1  one-cycle pulse; a drained beat is present on pop_data_o.
- pop_data_o  out  DW  drained beat data; holds its last value when pop_valid_o=0.
- err_o  out  1  one-cycle pulse, coincident with pop_valid_o, when the drained beat is out of sequence.
- rx_cnt  out  CNT_W  number of accepted beats; saturating.
- err_cnt  out  CNT_W  number of sequence errors; saturating.

## Operation
- Accept: acc = valid_i & ready_o. On acc, write data_i at wr_ptr, then advance wr_ptr mod DEPTH.
- Pop: pop = random_stall & (count != 0). On pop, read the head at rd_ptr, then advance rd_ptr mod DEPTH.
- Occupancy: count is CNT of log2(DEPTH)+1 bits and updates as count + acc - pop.
  - When acc and pop occur in the same cycle, count is unchanged and both pointers advance.
- ready_o is registered: ready_o <= (count_next < DEPTH). It has no combinational path from valid_i.
  - While ready_o=0, valid_i is ignored and no write occurs. A full FIFO can therefore never be overwritten.
- The sender may drop valid_i without a handshake. The receiver places no rule on valid persistence.
- Sequence checker, evaluated on each pop:
  - exp is a DW-bit register with reset value 1.
  - When head == exp: no error.
  - Otherwise: err_o pulses and err_cnt increments.
  - In both cases exp <= head + 1 mod 2^DW. The checker resyncs after an error, so a single bad beat produces exactly one error.
  - Wrap-around: 0xFF followed by 0x00 is in sequence.
- rx_cnt increments on each acc. Both rx_cnt and err_cnt stop at all-ones and never wrap.
- An error does not flush the FIFO or stop accepting.

## Timing
- Reset values: ready_o=0, pop_valid_o=0, pop_data_o=0, err_o=0, rx_cnt=0, err_cnt=0, count=0, pointers=0, exp=1.
- ready_o goes to 1 on the first rising edge after rst deasserts.
- Beat accepted at edge t:
  - Earliest pop is at edge t+1.
  - pop_valid_o, pop_data_o and err_o are registered and valid in the cycle after edge t+1.
  - Minimum latency from data_i to pop_data_o is 2 cycles.
- Full: count reaches DEPTH at edge t, so ready_o=0 in the cycle after t.
  - A pop at edge t+1 makes ready_o=1 after edge t+1.
  - Sustained throughput with random_stall=1 constantly is 1 beat/cycle.
- Empty: a pop request with count=0 does nothing and produces no pulse.
- Reset mid-operation:
  - All state returns to reset values asynchronously and in-flight entries are discarded.
  - The sender must also be reset, because exp restarts at 1.

## Test plan
- Reset release with valid_i=1, data_i=1, random_stall=1 → ready_o=0 at the first edge, 1 after it. Beats 1,2,3 appear on pop_data_o each 2 cycles after their accept. err_cnt=0, rx_cnt=3.
- Backpressure: random_stall=0, sender always valid, DEPTH=4 → exactly 4 accepts and ready_o=0. Then random_stall=1 → pops 1,2,3,4 in order, ready_o reasserts one cycle after the first pop, and no beat is lost or duplicated.
- Simultaneous push/pop at full (count=4, one pop plus a sender beat ready on the next cycle) → count stays at most 4 and the order is preserved.
- Wrap: send 1..255, 0, 1 with random sender valid and random_stall → err_cnt=0, rx_cnt=257, and pop_data_o shows 0xFF, 0x00, 0x01 consecutively.
- Injected error: stream 1,2,5,6 → exactly one err_o pulse, on beat 5. err_cnt=1 and beat 6 passes.
- Reset asserted with 3 entries held → outputs and counters go to 0 immediately. After release, stream 1,2 pops with no error.

Source files
------------

// File: rtl/handshake_receiver.sv
// handshake_receiver
//   Sink side of the 8-bit valid/ready handshake pair. Accepted beats go into
//   a small circular FIFO. A local consumer drains the FIFO whenever
//   random_stall is high. Every drained beat is checked against the sender's
//   incrementing sequence, and the block keeps saturating accept/error counts.
//
// Ports
//   clk           single rising-edge clock
//   rst           asynchronous active-high reset
//   random_stall  consumer enable: 1 = pop one entry this cycle if not empty
//   valid_i       beat valid from the sender
//   data_i        beat data from the sender
//   ready_o       registered accept capability back to the sender
//   pop_valid_o   one-cycle pulse: a drained beat is on pop_data_o
//   pop_data_o    drained beat data; holds its value between pops
//   err_o         one-cycle pulse with pop_valid_o when the beat is out of sequence
//   rx_cnt        accepted-beat count, saturating
//   err_cnt       sequence-error count, saturating
module handshake_receiver #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             random_stall,
    input  logic             valid_i,
    input  logic [DW-1:0]    data_i,
    output logic             ready_o,
    output logic             pop_valid_o,
    output logic [DW-1:0]    pop_data_o,
    output logic             err_o,
    output logic [CNT_W-1:0] rx_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] head;
    logic          acc;
    logic          pop;

    always_comb begin
        acc        = valid_i & ready_o;
        pop        = random_stall & (count != '0);
        head       = mem[rd_ptr];
        count_next = count + CW'(acc) - CW'(pop);
    end

    // Storage is not reset: an entry is only read while count says it holds
    // a beat written after the last reset.
    always_ff @(posedge clk) begin
        if (acc) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ready_o     <= 1'b0;
            pop_valid_o <= 1'b0;
            pop_data_o  <= '0;
            err_o       <= 1'b0;
            exp_data    <= DW'(1);
            rx_cnt      <= '0;
            err_cnt     <= '0;
        end else begin
            count <= count_next;
            // Registered from the post-update occupancy, so a pop this cycle
            // reopens the input on the very next cycle.
            ready_o     <= (count_next < CW'(DEPTH));
            pop_valid_o <= pop;
            err_o       <= pop && (head != exp_data);

            // Pointers are AW bits wide, so power-of-two DEPTH wraps for free.
            if (acc) wr_ptr <= wr_ptr + 1'b1;
            if (acc && (rx_cnt != '1)) rx_cnt <= rx_cnt + 1'b1;

            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                pop_data_o <= head;
                // Resync on every pop so one bad beat costs exactly one error.
                exp_data   <= head + 1'b1;
                if ((head != exp_data) && (err_cnt != '1))
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
